// File: rtl/fx_noise_gate.sv
// fx_noise_gate -- stereo noise gate with hysteresis, hold and attack/release
// gain ramps.
//
// Ports:
//   clk, reset      single clock; synchronous active-high reset
//   sample_en       one-cycle pulse per audio sample; all state advances here
//   audio_in        signed stereo input, [0]=L, [1]=R
//   fx_threshold    open threshold, scaled x128 (close threshold is half)
//   fx_attack       gain ramp-up rate, step = (fx_attack+1)<<4 per sample
//   fx_hold         hold time in units of 16 samples
//   fx_release      gain ramp-down rate, step = (fx_release+1)<<2 per sample
//   audio_out       gated stereo output, registered, one clk after sample_en
//   gate_open       high whenever the gate state is not CLOSED
module fx_noise_gate #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_en,
    input  logic signed [1:0][DATA_W-1:0]  audio_in,
    input  logic        [PARAM_W-1:0]      fx_threshold,
    input  logic        [PARAM_W-1:0]      fx_attack,
    input  logic        [PARAM_W-1:0]      fx_hold,
    input  logic        [PARAM_W-1:0]      fx_release,
    output logic signed [1:0][DATA_W-1:0]  audio_out,
    output logic                           gate_open
);

    localparam logic [2:0] ST_CLOSED  = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam int          HOLD_W = PARAM_W + 4;
    localparam logic [15:0] UNITY  = 16'h8000;

    // |x| with the most negative code clamped to the most positive one.
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = ~x + 1'b1;
        if (x == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (x[DATA_W-1])
            return neg;
        else
            return x;
    endfunction

    // (x * gain) >>> 15 with gain in Q1.15. Gain never exceeds unity, so the
    // shifted product always fits back into DATA_W bits.
    function automatic logic signed [DATA_W-1:0] apply_gain(
        input logic signed [DATA_W-1:0] x,
        input logic        [15:0]       g
    );
        logic signed [DATA_W+16:0] prod;
        prod = (DATA_W+17)'(x) * (DATA_W+17)'($signed({1'b0, g}));
        return DATA_W'(prod >>> 15);
    endfunction

    logic [2:0]        state;
    logic [15:0]       gain;
    logic [HOLD_W-1:0] hold_cnt;

    logic [DATA_W-1:0] level_l;
    logic [DATA_W-1:0] level_r;
    logic [31:0]       level;
    logic [31:0]       open_thr;
    logic [31:0]       close_thr;
    logic [16:0]       attack_step;
    logic [16:0]       release_step;
    logic [16:0]       gain_up;
    logic              opened;
    logic              below_close;

    always_comb begin
        level_l      = abs_sat(audio_in[0]);
        level_r      = abs_sat(audio_in[1]);
        level        = (level_l > level_r) ? 32'(level_l) : 32'(level_r);
        open_thr     = 32'(fx_threshold) << 7;
        close_thr    = open_thr >> 1;
        opened       = (level >= open_thr);
        below_close  = (level < close_thr);
        attack_step  = 17'((32'(fx_attack) + 32'd1) << 4);
        release_step = 17'((32'(fx_release) + 32'd1) << 2);
        gain_up      = {1'b0, gain} + attack_step;
    end

    // Output register: uses the gain held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_out <= '0;
        end else if (sample_en) begin
            audio_out[0] <= apply_gain(audio_in[0], gain);
            audio_out[1] <= apply_gain(audio_in[1], gain);
        end
    end

    // Gate control: state, gain ramp and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLOSED;
            gain     <= '0;
            hold_cnt <= '0;
        end else if (sample_en) begin
            case (state)
                ST_CLOSED: begin
                    gain <= '0;
                    if (opened)
                        state <= ST_ATTACK;
                end
                ST_ATTACK: begin
                    // Level is deliberately not re-checked while ramping up.
                    if (gain_up >= {1'b0, UNITY}) begin
                        gain  <= UNITY;
                        state <= ST_OPEN;
                    end else begin
                        gain <= gain_up[15:0];
                    end
                end
                ST_OPEN: begin
                    gain <= UNITY;
                    if (below_close) begin
                        state    <= ST_HOLD;
                        hold_cnt <= {fx_hold, 4'b0000};
                    end
                end
                ST_HOLD: begin
                    if (opened)
                        state <= ST_OPEN;
                    else if (hold_cnt == '0)
                        state <= ST_RELEASE;
                    else
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                ST_RELEASE: begin
                    // Re-trigger keeps the partial gain and ramps up from it.
                    if (opened) begin
                        state <= ST_ATTACK;
                    end else if ({1'b0, gain} <= release_step) begin
                        gain  <= '0;
                        state <= ST_CLOSED;
                    end else begin
                        gain <= gain - release_step[15:0];
                    end
                end
                default: begin
                    state <= ST_CLOSED;
                    gain  <= '0;
                end
            endcase
        end
    end

    assign gate_open = (state != ST_CLOSED);

endmodule

// File: tb/tb_fx_noise_gate.sv
module tb_fx_noise_gate;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     sample_en;
    logic signed [1:0][15:0]  audio_in;
    logic        [7:0]        fx_threshold;
    logic        [7:0]        fx_attack;
    logic        [7:0]        fx_hold;
    logic        [7:0]        fx_release;
    logic signed [1:0][15:0]  audio_out;
    logic                     gate_open;

    always #5 clk = ~clk;

    fx_noise_gate #(.DATA_W(16), .PARAM_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_en    (sample_en),
        .audio_in     (audio_in),
        .fx_threshold (fx_threshold),
        .fx_attack    (fx_attack),
        .fx_hold      (fx_hold),
        .fx_release   (fx_release),
        .audio_out    (audio_out),
        .gate_open    (gate_open)
    );

    typedef struct {
        int o0;
        int o1;
        int go;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: 0 CLOSED, 1 ATTACK, 2 OPEN, 3 HOLD, 4 RELEASE
    int m_state = 0;
    int m_gain  = 0;
    int m_hold  = 0;
    int last_o0 = 0;
    int last_o1 = 0;
    int last_go = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_gain  = 0;
        m_hold  = 0;
        last_o0 = 0;
        last_o1 = 0;
        last_go = 0;
    endtask

    task automatic model_step(input int l, input int r,
                              output int o0, output int o1, output int go);
        int al, ar, lvl, othr, cthr, ast, rst;
        o0 = (l * m_gain) >>> 15;
        o1 = (r * m_gain) >>> 15;
        al = (l < 0) ? -l : l;
        ar = (r < 0) ? -r : r;
        if (al > 32767) al = 32767;
        if (ar > 32767) ar = 32767;
        lvl  = (al > ar) ? al : ar;
        othr = int'(fx_threshold) * 128;
        cthr = othr / 2;
        ast  = (int'(fx_attack) + 1) * 16;
        rst  = (int'(fx_release) + 1) * 4;
        case (m_state)
            0: begin
                m_gain = 0;
                if (lvl >= othr) m_state = 1;
            end
            1: begin
                m_gain = m_gain + ast;
                if (m_gain >= 32768) begin
                    m_gain  = 32768;
                    m_state = 2;
                end
            end
            2: begin
                m_gain = 32768;
                if (lvl < cthr) begin
                    m_state = 3;
                    m_hold  = int'(fx_hold) * 16;
                end
            end
            3: begin
                if (lvl >= othr)      m_state = 2;
                else if (m_hold == 0) m_state = 4;
                else                  m_hold = m_hold - 1;
            end
            default: begin
                if (lvl >= othr) begin
                    m_state = 1;
                end else begin
                    m_gain = m_gain - rst;
                    if (m_gain <= 0) begin
                        m_gain  = 0;
                        m_state = 0;
                    end
                end
            end
        endcase
        go = (m_state != 0) ? 1 : 0;
    endtask

    // One sample: predict, push, clock, pop and compare.
    task automatic do_sample(input int l, input int r, input string tag);
        exp_t e;
        int   o0, o1, go;
        audio_in[0] = 16'(l);
        audio_in[1] = 16'(r);
        sample_en   = 1'b1;
        model_step(l, r, o0, o1, go);
        e.o0 = o0;
        e.o1 = o1;
        e.go = go;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        e = sbq.pop_front();
        chk({tag, "_out_l"}, int'($signed(audio_out[0])), e.o0);
        chk({tag, "_out_r"}, int'($signed(audio_out[1])), e.o1);
        chk({tag, "_gate"},  int'(gate_open), e.go);
        last_o0 = e.o0;
        last_o1 = e.o1;
        last_go = e.go;
    endtask

    // Cycles without sample_en: outputs must not move even if inputs do.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            audio_in[0] = 16'($urandom_range(0, 65535));
            audio_in[1] = 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            chk({tag, "_hold_l"}, int'($signed(audio_out[0])), last_o0);
            chk({tag, "_hold_r"}, int'($signed(audio_out[1])), last_o1);
            chk({tag, "_hold_gate"}, int'(gate_open), last_go);
        end
    endtask

    task automatic do_reset(input logic with_sample, input string tag);
        reset     = 1'b1;
        sample_en = with_sample;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        sample_en = 1'b0;
        model_reset();
        chk({tag, "_rst_l"}, int'($signed(audio_out[0])), 0);
        chk({tag, "_rst_r"}, int'($signed(audio_out[1])), 0);
        chk({tag, "_rst_gate"}, int'(gate_open), 0);
    endtask

    initial begin
        reset        = 1'b1;
        sample_en    = 1'b0;
        audio_in     = '0;
        fx_threshold = 8'd0;
        fx_attack    = 8'd255;
        fx_hold      = 8'd0;
        fx_release   = 8'd0;

        // Reset state
        @(posedge clk);
        do_reset(1'b0, "init");

        // Bypass: threshold 0, fast attack, DC 10000
        fx_threshold = 8'd0;
        fx_attack    = 8'd255;
        do_sample(10000, 10000, "byp_first");
        chk("byp_gate_after_first", int'(gate_open), 1);
        for (int i = 0; i < 11; i++) do_sample(10000, 10000, "byp");
        chk("byp_unity_l", int'($signed(audio_out[0])), 10000);
        chk("byp_unity_r", int'($signed(audio_out[1])), 10000);
        idle(3, "byp");

        // Below threshold: gate stays closed for 100 samples
        do_reset(1'b0, "closed");
        fx_threshold = 8'd64;
        for (int i = 0; i < 100; i++) do_sample(2000, 2000, "closed");
        chk("closed_out_final", int'($signed(audio_out[0])), 0);
        chk("closed_gate_final", int'(gate_open), 0);

        // Hysteresis, hold and release to closed
        fx_attack  = 8'd255;
        fx_hold    = 8'd1;
        fx_release = 8'd255;
        for (int i = 0; i < 10; i++) do_sample(15000, 15000, "hyst_open");
        for (int i = 0; i < 10; i++) do_sample(6000, -6000, "hyst_mid");
        chk("hyst_stays_open", int'(gate_open), 1);
        chk("hyst_unity_r", int'($signed(audio_out[1])), -6000);
        for (int i = 0; i < 49; i++) do_sample(3000, 3000, "hold_rel");
        chk("rel_still_open", int'(gate_open), 1);
        do_sample(3000, 3000, "rel_last");
        chk("rel_closed", int'(gate_open), 0);
        for (int i = 0; i < 5; i++) do_sample(3000, 3000, "rel_after");
        chk("rel_out_zero", int'($signed(audio_out[0])), 0);
        idle(2, "rel");

        // Re-trigger during release resumes from the partial gain
        fx_hold = 8'd0;
        for (int i = 0; i < 10; i++) do_sample(15000, 15000, "retrig_open");
        for (int i = 0; i < 12; i++) do_sample(3000, 3000, "retrig_rel");
        do_sample(15000, 15000, "retrig_a");
        do_sample(15000, 15000, "retrig_b");
        chk("retrig_partial_gain", int'($signed(audio_out[0])), 10312);

        // Full-scale negative passes unity bit-exact
        for (int i = 0; i < 5; i++) do_sample(15000, 15000, "fs_open");
        do_sample(-32768, 0, "fs_a");
        do_sample(-32768, 0, "fs_b");
        chk("fs_out_l", int'($signed(audio_out[0])), -32768);
        chk("fs_out_r", int'($signed(audio_out[1])), 0);
        chk("fs_gate", int'(gate_open), 1);

        // Mixed levels with changing controls
        fx_threshold = 8'd32;
        for (int i = 0; i < 60; i++) begin
            if (i % 20 == 0) begin
                fx_attack  = 8'($urandom_range(0, 255));
                fx_release = 8'($urandom_range(0, 255));
                fx_hold    = 8'($urandom_range(0, 2));
            end
            if ((i / 10) % 2 == 0)
                do_sample($urandom_range(0, 20000) - 10000, $urandom_range(0, 2000), "mix");
            else
                do_sample($urandom_range(0, 1500), -int'($urandom_range(0, 1500)), "mix");
        end

        // Reset coincident with sample_en in the middle of an attack ramp
        do_reset(1'b0, "mid");
        fx_threshold = 8'd0;
        fx_attack    = 8'd0;
        for (int i = 0; i < 5; i++) do_sample(10000, 10000, "mid_attack");
        chk("mid_attack_out", int'($signed(audio_out[0])), (10000 * 48) >>> 15);
        do_reset(1'b1, "mid");
        do_sample(10000, 10000, "restart_a");
        chk("restart_out_zero", int'($signed(audio_out[0])), 0);
        do_sample(10000, 10000, "restart_b");
        do_sample(10000, 10000, "restart_c");
        chk("restart_ramp", int'($signed(audio_out[0])), (10000 * 16) >>> 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fx_noise_gate.md
FX_NOISE_GATE -- requirements
Module: fx_noise_gate

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, meaning audio sample width per channel.
REQ-002 The block SHALL expose parameter PARAM_W, default 8, meaning width of each fx_* control.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  system clock (50 MHz).
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port sample_en  input  1  one-clk pulse per audio sample; all state advances only on these cycles.
REQ-007 Port audio_in  input  signed [1:0][DATA_W-1:0]  stereo input, [0]=L, [1]=R.
REQ-008 Port fx_threshold  input  PARAM_W  open threshold, scaled x128.
REQ-009 Port fx_attack  input  PARAM_W  gain ramp-up rate.
REQ-010 Port fx_hold  input  PARAM_W  hold time in units of 16 samples.
REQ-011 Port fx_release  input  PARAM_W  gain ramp-down rate.
REQ-012 Port audio_out  output  signed [1:0][DATA_W-1:0]  gated stereo output, feeds the compressor audio_in.
REQ-013 Port gate_open  output  1  high whenever state is not CLOSED.

Function
REQ-014 Level detection SHALL be level = max(|L|,|R|), 16-bit unsigned, with |-32768| saturated to 32767.
REQ-015 Thresholds SHALL be open_thr = fx_threshold*128 and close_thr = open_thr>>1; hysteresis compares use level >= open_thr and level < close_thr.
REQ-016 Gain SHALL be 16-bit unsigned Q1.15, range 0..0x8000, where 0x8000 = unity.
REQ-017 Attack step SHALL be (fx_attack+1)<<4 and release step SHALL be (fx_release+1)<<2; gain saturates at 0x8000 and at 0.
REQ-018 States SHALL be CLOSED, ATTACK, OPEN, HOLD, RELEASE; transitions are evaluated only on sample_en cycles.
REQ-019 CLOSED: gain=0; level>=open_thr -> ATTACK.
REQ-020 ATTACK: gain+=attack step; reaching 0x8000 -> OPEN. Level is not re-checked during attack.
REQ-021 OPEN: gain=0x8000; level<close_thr -> HOLD with hold_cnt loaded to fx_hold*16.
REQ-022 HOLD: level>=open_thr -> OPEN; else if hold_cnt==0 -> RELEASE; else hold_cnt-=1. fx_hold=0 SHALL reach RELEASE on the next sample.
REQ-023 RELEASE: level>=open_thr -> ATTACK with gain continuing from its current value; else gain-=release step; reaching 0 -> CLOSED.
REQ-024 On a sample_en cycle, audio_out[c] SHALL be (audio_in[c]*gain)>>>15, using the gain held before that edge; the product is 33-bit signed and arithmetic-shifted. Output latency is 1 clk.
REQ-025 audio_out SHALL hold its value between sample_en pulses.
REQ-026 fx_* changes SHALL take effect on the next sample_en; hold_cnt is not reloaded mid-HOLD.
REQ-027 fx_threshold=0 SHALL give open_thr=0, so the gate opens and never closes (bypass after ramp).
REQ-028 Unity gain SHALL pass input bit-exact, including -32768.

Reset
REQ-029 When reset=1 at a clk edge, the following SHALL apply on that edge regardless of sample_en or current state: state=CLOSED, gain=0, hold_cnt=0, audio_out=0 both channels, gate_open=0.

Verification
REQ-030 fx_threshold=0, fx_attack=255 (step 4096), DC 10000 both channels -> ATTACK on sample 1, OPEN after 8 samples, then audio_out=10000 exactly and gate_open=1.
REQ-031 fx_threshold=64 (open 8192, close 4096), DC 2000 -> stays CLOSED, audio_out=0, gate_open=0 for 100 samples.
REQ-032 Open gate at 15000, then apply 6000 -> stays OPEN (hysteresis). Then apply 3000 with fx_hold=1 and fx_release=255 (step 1024) -> 16 samples HOLD, 32 samples RELEASE, then CLOSED with audio_out=0.
REQ-033 In RELEASE, reapply 15000 -> ATTACK resumes from the partial gain, with no jump to 0 and no jump to unity.
REQ-034 Open gate, then drive L=-32768 and R=0 -> level 32767, audio_out[0]=-32768 and audio_out[1]=0.
REQ-035 Assert reset mid-ATTACK, coincident with sample_en -> next cycle state=CLOSED, gain=0, audio_out=0, and the ramp restarts from 0.
